// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Instruction queue between the fetch and dispatch stages. It hides
//   instruction-memory latency from dispatch stalls. Each entry holds one
//   {instr, pc} pair. Both sides use a valid/ready handshake. A flush from
//   branch resolution empties the queue at the next edge.
//
// Parameters
//   DEPTH   number of entries (power of two, >= 2)
//   WORD_W  width of instr and pc
//
// Ports
//   CLK             system clock, rising edge
//   nRST            asynchronous active-low reset
//   flush           discard all entries; takes priority over push and pop
//   fetch_valid     fetch presents an instruction
//   fetch_instr     instruction word
//   fetch_pc        pc of the instruction
//   fetch_ready     buffer can accept a push this cycle (state only)
//   dispatch_ready  dispatch consumes the head this cycle
//   dispatch_valid  head entry is valid
//   dispatch_instr  head instruction (0 when empty)
//   dispatch_pc     head pc (0 when empty)
//   count           current occupancy
// -----------------------------------------------------------------------------
module fetch_buffer #(
   parameter int DEPTH  = 4,
   parameter int WORD_W = 32
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       flush,
   input  logic                       fetch_valid,
   input  logic [WORD_W-1:0]          fetch_instr,
   input  logic [WORD_W-1:0]          fetch_pc,
   output logic                       fetch_ready,
   input  logic                       dispatch_ready,
   output logic                       dispatch_valid,
   output logic [WORD_W-1:0]          dispatch_instr,
   output logic [WORD_W-1:0]          dispatch_pc,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("fetch_buffer: DEPTH must be a power of two and >= 2");
      end
   endgenerate

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  occ;
   logic [WORD_W-1:0] mem_instr [DEPTH];
   logic [WORD_W-1:0] mem_pc    [DEPTH];
   logic              push;
   logic              pop;

   // Ready/valid come from occupancy alone, so dispatch_ready never reaches
   // fetch_ready combinationally; a full buffer refuses a push even when it
   // is popped in the same cycle.
   assign fetch_ready    = (occ != FULL_CNT);
   assign dispatch_valid = (occ != '0);
   assign dispatch_instr = dispatch_valid ? mem_instr[head] : '0;
   assign dispatch_pc    = dispatch_valid ? mem_pc[head]    : '0;
   assign count          = occ;

   assign push = fetch_valid    && fetch_ready    && !flush;
   assign pop  = dispatch_valid && dispatch_ready && !flush;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   occ <= occ + CNT_W'(1);
            2'b01:   occ <= occ - CNT_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Payload storage needs no reset: it is only observed through head while
   // occupancy is non-zero.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_instr[tail] <= fetch_instr;
         mem_pc[tail]    <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

   localparam int DEPTH  = 4;
   localparam int WORD_W = 32;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic              fetch_valid;
   logic [WORD_W-1:0] fetch_instr;
   logic [WORD_W-1:0] fetch_pc;
   logic              fetch_ready;
   logic              dispatch_ready;
   logic              dispatch_valid;
   logic [WORD_W-1:0] dispatch_instr;
   logic [WORD_W-1:0] dispatch_pc;
   logic [2:0]        count;

   int checks   = 0;
   int failures = 0;

   // Expected queue contents: {instr, pc} in FIFO order.
   logic [2*WORD_W-1:0] exp_q [$];

   fetch_buffer #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
      .CLK            (clk),
      .nRST           (rst_n),
      .flush          (flush),
      .fetch_valid    (fetch_valid),
      .fetch_instr    (fetch_instr),
      .fetch_pc       (fetch_pc),
      .fetch_ready    (fetch_ready),
      .dispatch_ready (dispatch_ready),
      .dispatch_valid (dispatch_valid),
      .dispatch_instr (dispatch_instr),
      .dispatch_pc    (dispatch_pc),
      .count          (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, req, $time);
      end
   endtask

   // Monitor/scoreboard: compares outputs in mid-cycle, then advances the
   // reference queue by what the coming rising edge should do.
   always @(negedge clk) begin
      logic [2*WORD_W-1:0] head_e;
      bit do_push;
      bit do_pop;
      if (!rst_n) begin
         chk("rst_count", 32'(count), 32'd0);
         chk("rst_dvalid", 32'(dispatch_valid), 32'd0);
         chk("rst_fready", 32'(fetch_ready), 32'd1);
         chk("rst_instr", dispatch_instr, 32'd0);
         chk("rst_pc", dispatch_pc, 32'd0);
         exp_q.delete();
      end else begin
         chk("count", 32'(count), 32'(exp_q.size()));
         chk("fetch_ready", 32'(fetch_ready), 32'(exp_q.size() != DEPTH));
         chk("dispatch_valid", 32'(dispatch_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            head_e = exp_q[0];
            chk("head_instr", dispatch_instr, head_e[2*WORD_W-1:WORD_W]);
            chk("head_pc", dispatch_pc, head_e[WORD_W-1:0]);
         end else begin
            chk("empty_instr", dispatch_instr, 32'd0);
            chk("empty_pc", dispatch_pc, 32'd0);
         end
         do_push = fetch_valid && (exp_q.size() != DEPTH);
         do_pop  = dispatch_ready && (exp_q.size() != 0);
         if (flush) begin
            exp_q.delete();
         end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({fetch_instr, fetch_pc});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit fv, input logic [31:0] ins, input logic [31:0] pc,
                        input bit dr, input bit fl);
      fetch_valid    = fv;
      fetch_instr    = ins;
      fetch_pc       = pc;
      dispatch_ready = dr;
      flush          = fl;
   endtask

   initial begin
      logic [31:0] pc_n;
      bit acc;
      rst_n = 1'b0;
      drive(1'b1, 32'hDEAD_BEEF, 32'h40, 1'b0, 1'b0);
      repeat (3) step();

      // Reset release and first push.
      rst_n = 1'b1;
      drive(1'b1, 32'h00A0_0093, 32'h0, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();

      // Fill with pc 0x0..0x10 while dispatch stalls; 0x10 is refused.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, $urandom, 32'(i * 4), 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (2) step();

      // Drain from full while pushing 0x10..0x1C; tail and head wrap.
      pc_n = 32'h10;
      for (int i = 0; i < 14; i++) begin
         drive(pc_n <= 32'h1C, $urandom, pc_n, 1'b1, 1'b0);
         acc = fetch_ready && fetch_valid;
         step();
         if (acc) pc_n = pc_n + 32'd4;
      end

      // Steady simultaneous push/pop at occupancy 2.
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      step();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, $urandom, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
         step();
      end
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, $urandom, 32'h208 + 32'(i * 4), 1'b1, 1'b0);
         step();
      end

      // Flush at occupancy 3 with push and pop requested in the same cycle.
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 32'h1111_1111, 32'h30C, 1'b1, 1'b1);
      step();
      drive(1'b1, 32'h0000_0113, 32'h100, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();

      // Asynchronous reset between edges at occupancy 3.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, $urandom, 32'h400 + 32'(i * 4), 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      rst_n = 1'b0;
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_dvalid", 32'(dispatch_valid), 32'd0);
      chk("async_fready", 32'(fetch_ready), 32'd1);
      step();
      rst_n = 1'b1;
      step();

      // Randomised traffic with occasional flush.
      for (int i = 0; i < 500; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom, $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      repeat (DEPTH + 2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Parameterised instruction queue between the fetch stage and the dispatch stage.
- Decouples instruction-memory latency from dispatch stalls.
- Each entry holds one fetch/dispatch latch payload (instr, pc).
- Fetch pushes with a valid/ready handshake; dispatch pops with a valid/ready handshake; a flush from branch resolution empties the queue.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- WORD_W, 32, width of instr and pc (matches word_t).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  discard all entries (mispredict or redirect).
- fetch_valid  in  1  fetch presents an instruction.
- fetch_instr  in  WORD_W  instruction word.
- fetch_pc  in  WORD_W  pc of the instruction.
- fetch_ready  out  1  buffer can accept a push this cycle.
- dispatch_ready  in  1  dispatch consumes the head this cycle.
- dispatch_valid  out  1  head entry is valid.
- dispatch_instr  out  WORD_W  head instruction.
- dispatch_pc  out  WORD_W  head pc.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage:
  - Circular array of DEPTH {instr, pc} entries.
  - head and tail pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - count is held explicitly to distinguish full from empty.
- Reset (nRST low, asynchronous): head=0, tail=0, count=0. Storage contents are don't-care.
- Outputs, all combinational from state only:
  - fetch_ready = (count != DEPTH). It does not depend on dispatch_ready, so there is no combinational path from dispatch to fetch.
  - dispatch_valid = (count != 0).
  - dispatch_instr and dispatch_pc = entry[head] when count != 0, else 0.
  - After reset: fetch_ready=1, dispatch_valid=0, dispatch_instr=0, dispatch_pc=0, count=0.
- Push: fetch_valid && fetch_ready && !flush. Writes entry[tail] and increments tail at the rising edge.
- Pop: dispatch_valid && dispatch_ready && !flush. Increments head at the rising edge.
- Latency: an entry pushed at edge N is visible on dispatch_* after edge N. There is no same-cycle bypass: minimum fetch-to-dispatch latency is 1 cycle.
- count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop. This is legal at any occupancy 1..DEPTH-1.
  - When full, push is blocked by fetch_ready=0 even if a pop occurs that cycle.
  - When empty, pop is impossible (dispatch_valid=0).
- Flush:
  - At the next edge: head=tail=0, count=0.
  - Any push or pop in the flush cycle is discarded. Flush has priority over both.
  - In the cycle after flush: dispatch_valid=0, fetch_ready=1.
- Order: strictly FIFO, including across pointer wrap.
- Holding: when dispatch_ready=0, dispatch_instr and dispatch_pc stay stable while dispatch_valid=1.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge.
- Illegal parameter (DEPTH not a power of two, or < 2): the implementation shall fail elaboration.

Test Plan:
- Reset: hold nRST=0 with fetch_valid=1 -> dispatch_valid=0, fetch_ready=1, count=0, dispatch_instr=0. Release nRST, push instr 0x00A00093 pc 0x0 -> after one edge, dispatch_valid=1, dispatch_instr=0x00A00093, dispatch_pc=0x0, count=1.
- Fill: dispatch_ready=0, push 5 words with pc 0x0,0x4,0x8,0xC,0x10 (DEPTH=4) -> fetch_ready=0 after the 4th edge, count=4, pc 0x10 not accepted. Head stays at pc 0x0 until popped.
- Drain with wrap: from full, assert dispatch_ready while pushing pc 0x10..0x1C -> dispatch_pc sequence is 0x0,0x4,0x8,0xC,0x10,... with no gaps or duplicates after tail wraps.
- Steady-state simultaneous push and pop at count=2 for 20 cycles -> count stays 2; output pc stream is exactly the input stream delayed by two entries.
- Flush: count=3 with fetch_valid=1 and dispatch_ready=1 in the flush cycle -> next cycle count=0, dispatch_valid=0, fetch_ready=1. The next push (pc 0x100) appears as head after one edge.
- Asynchronous reset mid-stream: count=3, drop nRST between clock edges -> count=0 and dispatch_valid=0 immediately, before the next CLK edge.
